// File: rtl/cci_mpf_shim_buffer_afu_if.sv
// CCI-style request/response bundle. to_afu faces the AFU (shim drives RX, almost-full and reset).
// to_qlp faces the QLP (shim drives TX).
interface cci_mpf_if #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61
);
  logic                        resetb;
  logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr;
  logic                        C0TxRdValid;
  logic                        C0TxAlmFull;
  logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr;
  logic [CCI_DATA_WIDTH-1:0]   C1TxData;
  logic                        C1TxWrValid;
  logic                        C1TxIrValid;
  logic                        C1TxAlmFull;
  logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr;
  logic [CCI_DATA_WIDTH-1:0]   C0RxData;
  logic                        C0RxWrValid;
  logic                        C0RxRdValid;
  logic                        C0RxIrValid;
  logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr;
  logic                        C1RxWrValid;
  logic                        C1RxIrValid;

  modport to_afu (
    output resetb,
    input  C0TxHdr, C0TxRdValid, C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
    output C0TxAlmFull, C1TxAlmFull,
    output C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid, C0RxIrValid,
    output C1RxHdr, C1RxWrValid, C1RxIrValid
  );

  modport to_qlp (
    input  resetb,
    output C0TxHdr, C0TxRdValid, C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
    input  C0TxAlmFull, C1TxAlmFull,
    input  C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid, C0RxIrValid,
    input  C1RxHdr, C1RxWrValid, C1RxIrValid
  );
endinterface

// File: rtl/cci_mpf_shim_buffer_afu.sv
// AFU-side TX buffering shim: per-channel FIFOs with registered single-pulse issue toward the QLP.
// Optional macro CCI_MPF_SHIM_BUFFER_AFU_BYPASS_EN lets a request skip an empty FIFO (1-cycle latency).
module cci_mpf_shim_buffer_afu_chan #(
  parameter int W         = 8,
  parameter int N_ENTRIES = 8,
  parameter int THRESHOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         qlp_almfull,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         almfull,
  output logic         err_overflow
);
  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [W-1:0]  mem [N_ENTRIES];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, cnt_next;
  logic          empty, full, deq, enq, byp, ovf;

  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == CW'(N_ENTRIES));
    deq   = !empty && !qlp_almfull;
`ifdef CCI_MPF_SHIM_BUFFER_AFU_BYPASS_EN
    byp   = in_valid && empty && !qlp_almfull;
`else
    byp   = 1'b0;
`endif
    // a full FIFO still accepts when its head leaves on the same edge
    enq      = in_valid && !byp && (!full || deq);
    ovf      = in_valid && full && !deq;
    cnt_next = cnt + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      wptr         <= '0;
      rptr         <= '0;
      out_valid    <= 1'b0;
      almfull      <= 1'b1;
      err_overflow <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      out_valid    <= deq || byp;
      almfull      <= (cnt_next >= CW'(N_ENTRIES - THRESHOLD));
      err_overflow <= err_overflow || ovf;
    end
  end

  // payload storage carries no reset
  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= in_data;
    if (deq)      out_data <= mem[rptr];
    else if (byp) out_data <= in_data;
  end
endmodule

module cci_mpf_shim_buffer_afu #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_TAG_WIDTH    = 13,
  parameter int N_ENTRIES        = 8,
  parameter int THRESHOLD        = 4
) (
  input  logic            clk,
  input  logic            resetb,
  cci_mpf_if.to_afu       afu_raw,
  cci_mpf_if.to_qlp       qlp_buf,
  output logic [1:0]      err_overflow
);
  localparam int C1W = 1 + CCI_TX_HDR_WIDTH + CCI_DATA_WIDTH;

  if (CCI_TAG_WIDTH > CCI_TX_HDR_WIDTH || CCI_RX_HDR_WIDTH < 1 ||
      THRESHOLD < 1 || THRESHOLD >= N_ENTRIES) begin : g_bad_params
  end

  logic           c1_in_valid, c1_out_valid;
  logic [C1W-1:0] c1_in, c1_out;

  assign afu_raw.resetb      = resetb;
  assign afu_raw.C0RxHdr     = qlp_buf.C0RxHdr;
  assign afu_raw.C0RxData    = qlp_buf.C0RxData;
  assign afu_raw.C0RxWrValid = qlp_buf.C0RxWrValid;
  assign afu_raw.C0RxRdValid = qlp_buf.C0RxRdValid;
  assign afu_raw.C0RxIrValid = qlp_buf.C0RxIrValid;
  assign afu_raw.C1RxHdr     = qlp_buf.C1RxHdr;
  assign afu_raw.C1RxWrValid = qlp_buf.C1RxWrValid;
  assign afu_raw.C1RxIrValid = qlp_buf.C1RxIrValid;

  // write wins when the AFU raises both valids
  assign c1_in_valid = afu_raw.C1TxWrValid || afu_raw.C1TxIrValid;
  assign c1_in       = {afu_raw.C1TxIrValid && !afu_raw.C1TxWrValid, afu_raw.C1TxHdr, afu_raw.C1TxData};

  cci_mpf_shim_buffer_afu_chan #(
    .W(CCI_TX_HDR_WIDTH), .N_ENTRIES(N_ENTRIES), .THRESHOLD(THRESHOLD)
  ) u_c0 (
    .clk, .rst_n(resetb),
    .in_valid(afu_raw.C0TxRdValid), .in_data(afu_raw.C0TxHdr),
    .qlp_almfull(qlp_buf.C0TxAlmFull),
    .out_valid(qlp_buf.C0TxRdValid), .out_data(qlp_buf.C0TxHdr),
    .almfull(afu_raw.C0TxAlmFull), .err_overflow(err_overflow[0])
  );

  cci_mpf_shim_buffer_afu_chan #(
    .W(C1W), .N_ENTRIES(N_ENTRIES), .THRESHOLD(THRESHOLD)
  ) u_c1 (
    .clk, .rst_n(resetb),
    .in_valid(c1_in_valid), .in_data(c1_in),
    .qlp_almfull(qlp_buf.C1TxAlmFull),
    .out_valid(c1_out_valid), .out_data(c1_out),
    .almfull(afu_raw.C1TxAlmFull), .err_overflow(err_overflow[1])
  );

  assign qlp_buf.C1TxWrValid = c1_out_valid && !c1_out[C1W-1];
  assign qlp_buf.C1TxIrValid = c1_out_valid &&  c1_out[C1W-1];
  assign qlp_buf.C1TxHdr     = c1_out[C1W-2 -: CCI_TX_HDR_WIDTH];
  assign qlp_buf.C1TxData    = c1_out[CCI_DATA_WIDTH-1:0];
endmodule
